// File: rtl/mult_pkg.sv
// Shared definitions for the iterative mantissa multiplier: operand field layout,
// FSM encoding and the idle marker carried alongside each operation.
package mult_pkg;

    localparam int SIGN_BIT = 32;
    localparam int EXP_MSB  = 31;
    localparam int EXP_LSB  = 24;
    localparam int MANT_W   = 24;
    localparam int PROD_W   = 50;

    // Exponent forced onto a zero product so the normaliser sees the smallest exponent
    localparam logic [7:0] ZERO_EXP = 8'h82;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic {
        NO_IDLE  = 1'b0,
        PUT_IDLE = 1'b1
    } idle_t;

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: adds mant_a times a multiplier digit, shifted into
// position, to the running accumulator.
module mult_step #(
    parameter int BITS_PER_CYCLE = 2,
    parameter int MANT_W         = 24,
    parameter int ACC_W          = 48,
    parameter int SHIFT_W        = 6
) (
    input  logic [ACC_W-1:0]          acc_in,
    input  logic [MANT_W-1:0]         mant_a,
    input  logic [BITS_PER_CYCLE-1:0] digit,
    input  logic [SHIFT_W-1:0]        shift,
    output logic [ACC_W-1:0]          acc_out
);

    logic [ACC_W-1:0] terms [BITS_PER_CYCLE];
    logic [ACC_W-1:0] partial;

    // One gated, pre-shifted copy of mant_a per multiplier bit in the digit
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_term
        assign terms[gi] = digit[gi] ? (ACC_W'(mant_a) << gi) : '0;
    end

    always_comb begin
        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            partial = partial + terms[i];
        end
        acc_out = acc_in + (partial << shift);
    end

endmodule

// File: rtl/multiply_mant_iter.sv
// Iterative floating-point multiply stage: captures two unpacked operands, forms the
// unnormalised 48-bit mantissa product over ITER cycles and holds it for downstream.
module multiply_mant_iter
    import mult_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [32:0]         aout_Unpack,
    input  logic [32:0]         bout_Unpack,
    input  logic [7:0]          InsTagUnpack,
    input  logic                ScaleValidUnpack,
    input  logic [31:0]         z_Unpack,
    input  logic                idle_Unpack,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32:0]         zout_Multiply,
    output logic [PROD_W-1:0]   productout_Multiply,
    output logic [7:0]          InsTagMultiply,
    output logic                ScaleValidMultiply,
    output logic [31:0]         z_Multiply,
    output logic                idle_Multiply
);

    localparam int ITER    = MANT_W / BITS_PER_CYCLE;
    localparam int CNT_W   = $clog2(ITER);
    localparam int ACC_W   = 2 * MANT_W;
    localparam int SHIFT_W = 6;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    iter_reg;
    logic [MANT_W-1:0]   mant_a_reg;
    logic [MANT_W-1:0]   mult_reg;
    logic [ACC_W-1:0]    acc_reg;
    logic [ACC_W-1:0]    acc_next;
    logic [32:0]         zout_reg;
    logic [7:0]          tag_reg;
    logic                scale_reg;
    logic [31:0]         z_reg;
    idle_t               idle_reg;

    logic                accept;
    logic                sign_calc;
    logic [7:0]          exp_calc;
    logic                zero_op;
    logic [SHIFT_W-1:0]  shift;

    assign accept    = in_valid && (state_reg == S_IDLE);
    assign sign_calc = aout_Unpack[SIGN_BIT] ^ bout_Unpack[SIGN_BIT];
    // The +1 assumes the product MSB lands at bit 49; the normaliser undoes it otherwise
    assign exp_calc  = aout_Unpack[EXP_MSB:EXP_LSB] + bout_Unpack[EXP_MSB:EXP_LSB] + 8'd1;
    assign zero_op   = (aout_Unpack[MANT_W-1:0] == '0) || (bout_Unpack[MANT_W-1:0] == '0);
    assign shift     = SHIFT_W'(iter_reg) * SHIFT_W'(BITS_PER_CYCLE);

    mult_step #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .MANT_W         (MANT_W),
        .ACC_W          (ACC_W),
        .SHIFT_W        (SHIFT_W)
    ) u_step (
        .acc_in  (acc_reg),
        .mant_a  (mant_a_reg),
        .digit   (mult_reg[BITS_PER_CYCLE-1:0]),
        .shift   (shift),
        .acc_out (acc_next)
    );

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (in_valid) begin
                    state_next = (idle_Unpack || zero_op) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (iter_reg == CNT_W'(ITER - 1)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= S_IDLE;
            iter_reg   <= '0;
            mant_a_reg <= '0;
            mult_reg   <= '0;
            acc_reg    <= '0;
            zout_reg   <= '0;
            tag_reg    <= '0;
            scale_reg  <= 1'b0;
            z_reg      <= '0;
            idle_reg   <= NO_IDLE;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                tag_reg    <= InsTagUnpack;
                scale_reg  <= ScaleValidUnpack;
                z_reg      <= z_Unpack;
                idle_reg   <= idle_Unpack ? PUT_IDLE : NO_IDLE;
                mant_a_reg <= aout_Unpack[MANT_W-1:0];
                mult_reg   <= bout_Unpack[MANT_W-1:0];
                acc_reg    <= '0;
                iter_reg   <= '0;
                if (idle_Unpack) begin
                    zout_reg <= aout_Unpack;
                end else if (zero_op) begin
                    zout_reg <= {sign_calc, ZERO_EXP, {MANT_W{1'b0}}};
                end else begin
                    zout_reg <= {sign_calc, exp_calc, {MANT_W{1'b0}}};
                end
            end else if (state_reg == S_CALC) begin
                acc_reg  <= acc_next;
                mult_reg <= mult_reg >> BITS_PER_CYCLE;
                iter_reg <= iter_reg + 1'b1;
            end
        end
    end

    assign in_ready            = (state_reg == S_IDLE);
    assign out_valid           = (state_reg == S_DONE);
    assign zout_Multiply       = zout_reg;
    assign productout_Multiply = {acc_reg, 2'b00};
    assign InsTagMultiply      = tag_reg;
    assign ScaleValidMultiply  = scale_reg;
    assign z_Multiply          = z_reg;
    // Downstream samples every cycle, so anything not yet valid must read as idle
    assign idle_Multiply       = (idle_reg == PUT_IDLE) || !out_valid;

endmodule

// File: tb/tb_multiply_mant_iter.sv
// Directed-vector bench for multiply_mant_iter: table of operand sets with hand-computed
// results, plus back-pressure and mid-calculation reset sequences.
module tb_multiply_mant_iter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [32:0] aout_Unpack = '0;
    logic [32:0] bout_Unpack = '0;
    logic [7:0]  InsTagUnpack = '0;
    logic        ScaleValidUnpack = 1'b0;
    logic [31:0] z_Unpack = '0;
    logic        idle_Unpack = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [32:0] zout_Multiply;
    logic [49:0] productout_Multiply;
    logic [7:0]  InsTagMultiply;
    logic        ScaleValidMultiply;
    logic [31:0] z_Multiply;
    logic        idle_Multiply;

    multiply_mant_iter dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .aout_Unpack         (aout_Unpack),
        .bout_Unpack         (bout_Unpack),
        .InsTagUnpack        (InsTagUnpack),
        .ScaleValidUnpack    (ScaleValidUnpack),
        .z_Unpack            (z_Unpack),
        .idle_Unpack         (idle_Unpack),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .zout_Multiply       (zout_Multiply),
        .productout_Multiply (productout_Multiply),
        .InsTagMultiply      (InsTagMultiply),
        .ScaleValidMultiply  (ScaleValidMultiply),
        .z_Multiply          (z_Multiply),
        .idle_Multiply       (idle_Multiply)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [32:0] a;
        logic [32:0] b;
        logic [7:0]  tag;
        logic        scale;
        logic [31:0] z;
        logic        idle;
        logic [32:0] exp_zout;
        logic [49:0] exp_prod;
        int          exp_lat;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        aout_Unpack      = v.a;
        bout_Unpack      = v.b;
        InsTagUnpack     = v.tag;
        ScaleValidUnpack = v.scale;
        z_Unpack         = v.z;
        idle_Unpack      = v.idle;
        in_valid         = 1'b1;
    endtask

    // Offer one operand set and wait (bounded) for out_valid; returns cycles from accept.
    task automatic launch(input vec_t v, output int lat);
        drive(v);
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic check_result(input int idx, input vec_t v, input int lat);
        check($sformatf("lat%0d", idx), 64'(lat), 64'(v.exp_lat));
        check($sformatf("valid%0d", idx), 64'(out_valid), 64'd1);
        check($sformatf("zout%0d", idx), 64'(zout_Multiply), 64'(v.exp_zout));
        check($sformatf("prod%0d", idx), 64'(productout_Multiply), 64'(v.exp_prod));
        check($sformatf("tag%0d", idx), 64'(InsTagMultiply), 64'(v.tag));
        check($sformatf("scale%0d", idx), 64'(ScaleValidMultiply), 64'(v.scale));
        check($sformatf("z%0d", idx), 64'(z_Multiply), 64'(v.z));
        check($sformatf("idle%0d", idx), 64'(idle_Multiply), 64'(v.idle));
        $display("txn %0d lat=%0d zout=%h prod=%h tag=%h idle=%b", idx, lat,
                 zout_Multiply, productout_Multiply, InsTagMultiply, idle_Multiply);
    endtask

    task automatic consume(input int idx);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check($sformatf("drain_valid%0d", idx), 64'(out_valid), 64'd0);
        check($sformatf("drain_ready%0d", idx), 64'(in_ready), 64'd1);
        check($sformatf("drain_idle%0d", idx), 64'(idle_Multiply), 64'd1);
    endtask

    initial begin
        int lat;
        vec_t hold_v;

        //          a                b                tag    sc    z              idle  zout            product              lat
        vecs[0] = '{33'h0_00C0_0000, 33'h0_00C0_0000, 8'h11, 1'b0, 32'h0000_0001, 1'b0, 33'h0_0100_0000, 50'h2400000000000, 13};
        vecs[1] = '{33'h0_0080_0000, 33'h0_0080_0000, 8'h22, 1'b1, 32'h0000_0002, 1'b0, 33'h0_0100_0000, 50'h1000000000000, 13};
        vecs[2] = '{33'h1_03A0_0000, 33'h0_FE90_0000, 8'h5A, 1'b0, 32'hDEAD_BEEF, 1'b0, 33'h1_0200_0000, 50'h1680000000000, 13};
        vecs[3] = '{33'h1_2345_6789, 33'h0_1111_1111, 8'h33, 1'b1, 32'hCAFE_0003, 1'b1, 33'h1_2345_6789, 50'h0,             1};
        vecs[4] = '{33'h0_1000_0000, 33'h1_05C0_0000, 8'h44, 1'b0, 32'h0000_0004, 1'b0, 33'h1_8200_0000, 50'h0,             1};
        vecs[5] = '{33'h0_7FFF_FFFF, 33'h0_0000_0000, 8'h55, 1'b1, 32'h0000_0005, 1'b0, 33'h0_8200_0000, 50'h0,             1};
        vecs[6] = '{33'h0_7FFF_FFFF, 33'h0_7FFF_FFFF, 8'h66, 1'b0, 32'h0000_0006, 1'b0, 33'h0_FF00_0000, 50'h3FFFFF8000004, 13};
        vecs[7] = '{33'h1_8080_0001, 33'h1_8080_0003, 8'h77, 1'b1, 32'h0000_0007, 1'b0, 33'h0_0100_0000, 50'h100000800000C, 13};

        // Reset state
        #2;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_idle", 64'(idle_Multiply), 64'd1);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_prod", 64'(productout_Multiply), 64'd0);
        check("rst_zout", 64'(zout_Multiply), 64'd0);
        check("rst_tag", 64'(InsTagMultiply), 64'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            launch(vecs[i], lat);
            check_result(i, vecs[i], lat);
            consume(i);
        end

        // Back-pressure: hold in S_DONE, offer ignored inputs, outputs must not move
        launch(vecs[2], lat);
        check_result(100, vecs[2], lat);
        hold_v = vecs[6];
        for (int c = 0; c < 5; c++) begin
            drive(hold_v);
            @(posedge clock); #1;
            check($sformatf("hold_valid%0d", c), 64'(out_valid), 64'd1);
            check($sformatf("hold_ready%0d", c), 64'(in_ready), 64'd0);
            check($sformatf("hold_prod%0d", c), 64'(productout_Multiply), 64'(vecs[2].exp_prod));
            check($sformatf("hold_zout%0d", c), 64'(zout_Multiply), 64'(vecs[2].exp_zout));
            check($sformatf("hold_tag%0d", c), 64'(InsTagMultiply), 64'(vecs[2].tag));
        end
        in_valid = 1'b0;
        consume(100);

        // out_ready while nothing is valid must not disturb the next operation
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check("spur_ready", 64'(in_ready), 64'd1);

        // Reset in the middle of S_CALC
        drive(vecs[6]);
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check("calc_ready", 64'(in_ready), 64'd0);
        check("calc_valid", 64'(out_valid), 64'd0);
        check("calc_idle", 64'(idle_Multiply), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_idle", 64'(idle_Multiply), 64'd1);
        check("mrst_ready", 64'(in_ready), 64'd1);
        check("mrst_prod", 64'(productout_Multiply), 64'd0);
        check("mrst_zout", 64'(zout_Multiply), 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        launch(vecs[0], lat);
        check_result(200, vecs[0], lat);
        consume(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
